// File: rtl/div5_iter_ctrl_if.sv
// Handshake bundle for the iterative divide-by-5 unit: dividend request
// channel, result channel and the busy indicator.
interface div5_iter_ctrl_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quot;
    logic [2:0]       out_rem;
    logic             busy;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_quot,
        input  out_rem,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_quot,
        output out_rem,
        output busy
    );
endinterface

// File: rtl/div5_iter_ctrl.sv
// Sequential divide-by-5: one radix-8 digit-recurrence step per clock.
// Each step folds the running remainder (0..4) with the next three dividend
// bits, emitting a quotient digit and a new remainder. All outputs come
// straight from registers, so no input reaches an output combinationally.
module div5_iter_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    div5_iter_ctrl_if.slave bus
);
    localparam int STEPS = (WIDTH + 2) / 3;
    localparam int SRW   = 3 * STEPS;
    localparam int CW    = $clog2(STEPS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [SRW-1:0]   r_shiftReg;
    logic [WIDTH-1:0] r_quot;
    logic [2:0]       r_rem;
    logic [CW-1:0]    r_count;

    logic [5:0]       w_stepVal;
    logic [2:0]       w_digit;
    logic [2:0]       w_remNext;
    logic             w_lastStep;

    // The partial value never exceeds 4*8+7 = 39, so the digit fits in 3 bits.
    assign w_stepVal  = {r_rem, r_shiftReg[SRW-1 -: 3]};
    assign w_digit    = 3'(w_stepVal / 6'd5);
    assign w_remNext  = 3'(w_stepVal % 6'd5);
    assign w_lastStep = (r_count == CW'(STEPS - 1));

    // Control FSM and datapath: capture in IDLE, one digit per edge in RUN,
    // hold the result in DONE until the consumer takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shiftReg <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_shiftReg <= SRW'(bus.in_data);
                        r_quot     <= '0;
                        r_rem      <= '0;
                        r_count    <= '0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_shiftReg <= r_shiftReg << 3;
                    r_quot     <= WIDTH'({r_quot, w_digit});
                    r_rem      <= w_remNext;
                    r_count    <= r_count + CW'(1);
                    if (w_lastStep) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_quot  = r_quot;
    assign bus.out_rem   = r_rem;

    // A remainder of 5 or more would make every later digit wrong.
    a_remRange: assert property (@(posedge clk) r_rem < 3'd5);

endmodule

// File: tb/tb_div5_iter_ctrl.sv
// Directed and randomized checks for the iterative divide-by-5 unit.
module tb_div5_iter_ctrl;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    div5_iter_ctrl_if #(.WIDTH(64)) bus ();

    div5_iter_ctrl #(.WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Run one division: wait for in_ready, present x, wait for the result,
    // optionally stall the consumer, then complete the output handshake.
    task automatic do_div(input logic [63:0] x, input int preGap, input int holdGap,
                          output logic [63:0] q, output logic [2:0] r, output int lat,
                          output logic ok, output logic runReady, output logic validAfter);
        int t;
        ok = 1'b1;
        q = '0;
        r = '0;
        lat = 0;
        runReady = 1'b1;
        validAfter = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (preGap) begin
            @(posedge clk);
            #1;
        end
        t = 0;
        while (!bus.in_ready && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!bus.in_ready) begin
            ok = 1'b0;
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_data = x;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        runReady = bus.in_ready;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.out_valid) begin
            ok = 1'b0;
            return;
        end
        q = bus.out_quot;
        r = bus.out_rem;
        repeat (holdGap) begin
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        validAfter = bus.out_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_in_ready got=%b want=1", bus.in_ready);
        end
        total++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_valid_busy got=%b/%b want=0/0", bus.out_valid, bus.busy);
        end
        total++;
        if (bus.out_quot !== 64'd0 || bus.out_rem !== 3'd0) begin
            bad++;
            $display("[TB] FAIL reset_result got=%h/%0d want=0/0", bus.out_quot, bus.out_rem);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero();
        logic [63:0] q;
        logic [2:0]  r;
        int          lat;
        logic        ok, runReady, validAfter;
        do_div(64'd0, 0, 0, q, r, lat, ok, runReady, validAfter);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("[TB] FAIL zero_timeout got=%b want=1", ok);
        end
        total++;
        if (lat !== 22) begin
            bad++;
            $display("[TB] FAIL zero_latency got=%0d want=22", lat);
        end
        total++;
        if (runReady !== 1'b0) begin
            bad++;
            $display("[TB] FAIL zero_in_ready_run got=%b want=0", runReady);
        end
        total++;
        if (q !== 64'd0 || r !== 3'd0) begin
            bad++;
            $display("[TB] FAIL zero_result got=%h/%0d want=0/0", q, r);
        end
        total++;
        if (validAfter !== 1'b0) begin
            bad++;
            $display("[TB] FAIL zero_valid_after got=%b want=0", validAfter);
        end
    endtask

    task automatic test_values();
        logic [63:0] xs[4];
        logic [63:0] qs[4];
        logic [2:0]  rs[4];
        logic [63:0] q;
        logic [2:0]  r;
        int          lat;
        logic        ok, runReady, validAfter;
        xs[0] = 64'hFFFF_FFFF_FFFF_FFFF; qs[0] = 64'h3333_3333_3333_3333; rs[0] = 3'd0;
        xs[1] = 64'd7;                   qs[1] = 64'd1;                   rs[1] = 3'd2;
        xs[2] = 64'd1234567;             qs[2] = 64'd246913;              rs[2] = 3'd2;
        xs[3] = 64'h8000_0000_0000_0000; qs[3] = 64'h1999_9999_9999_9999; rs[3] = 3'd3;
        for (int i = 0; i < 4; i++) begin
            do_div(xs[i], 1, 0, q, r, lat, ok, runReady, validAfter);
            total++;
            if (ok !== 1'b1 || lat !== 22) begin
                bad++;
                $display("[TB] FAIL value%0d_latency got=%0d ok=%b want=22", i, lat, ok);
            end
            total++;
            if (q !== qs[i] || r !== rs[i]) begin
                bad++;
                $display("[TB] FAIL value%0d_result got=%h/%0d want=%h/%0d", i, q, r, qs[i], rs[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int t;
        bus.in_valid = 1'b1;
        bus.in_data = 64'd1234567;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        t = 0;
        while (!bus.out_valid && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bp_timeout got=%b want=1", bus.out_valid);
        end
        bus.in_valid = 1'b1;
        bus.in_data = 64'd99;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.out_quot !== 64'd246913 || bus.out_rem !== 3'd2) begin
                bad++;
                $display("[TB] FAIL bp_hold%0d got=v%b r%b %0d/%0d want=v1 r0 246913/2",
                         i, bus.out_valid, bus.in_ready, bus.out_quot, bus.out_rem);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bp_release got=v%b r%b want=v0 r1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ops[3];
        logic [63:0] expQ[3];
        logic [2:0]  expR[3];
        int          acceptCyc[3];
        int          acc, chk, cyc;
        logic        readyBefore, validBefore;
        ops[0] = 64'd100; expQ[0] = 64'd20; expR[0] = 3'd0;
        ops[1] = 64'd5;   expQ[1] = 64'd1;  expR[1] = 3'd0;
        ops[2] = 64'd38;  expQ[2] = 64'd7;  expR[2] = 3'd3;
        acc = 0;
        chk = 0;
        cyc = 0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = ops[0];
        while (chk < 3 && cyc < 200) begin
            readyBefore = bus.in_ready;
            validBefore = bus.in_valid;
            @(posedge clk);
            #1;
            cyc++;
            if (validBefore && readyBefore) begin
                acceptCyc[acc] = cyc;
                acc++;
                bus.in_valid = 1'b0;
            end
            if (bus.out_valid) begin
                total++;
                if (bus.out_quot !== expQ[chk] || bus.out_rem !== expR[chk]) begin
                    bad++;
                    $display("[TB] FAIL b2b_result%0d got=%0d/%0d want=%0d/%0d",
                             chk, bus.out_quot, bus.out_rem, expQ[chk], expR[chk]);
                end
                chk++;
            end
            if (acc < 3 && !bus.in_valid && bus.in_ready) begin
                bus.in_valid = 1'b1;
                bus.in_data = ops[acc];
            end
        end
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        total++;
        if (chk !== 3 || acc !== 3) begin
            bad++;
            $display("[TB] FAIL b2b_timeout got=%0d results want=3", chk);
        end else begin
            total++;
            if (acceptCyc[1] - acceptCyc[0] !== 24 || acceptCyc[2] - acceptCyc[1] !== 24) begin
                bad++;
                $display("[TB] FAIL b2b_interval got=%0d,%0d want=24,24",
                         acceptCyc[1] - acceptCyc[0], acceptCyc[2] - acceptCyc[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] q;
        logic [2:0]  r;
        int          lat;
        logic        ok, runReady, validAfter;
        bus.in_valid = 1'b1;
        bus.in_data = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_state got=r%b v%b b%b want=r1 v0 b0",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
        do_div(64'd25, 0, 0, q, r, lat, ok, runReady, validAfter);
        total++;
        if (ok !== 1'b1 || lat !== 22 || q !== 64'd5 || r !== 3'd0) begin
            bad++;
            $display("[TB] FAIL midreset_25 got=%0d/%0d lat=%0d want=5/0 lat=22", q, r, lat);
        end
    endtask

    task automatic test_random();
        logic [63:0] x, q, eq;
        logic [2:0]  r, er;
        int          lat;
        logic        ok, runReady, validAfter;
        for (int i = 0; i < 150; i++) begin
            x = {$urandom(), $urandom()};
            eq = x / 64'd5;
            er = 3'(x % 64'd5);
            do_div(x, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                   q, r, lat, ok, runReady, validAfter);
            total++;
            if (ok !== 1'b1 || q !== eq || r !== er || r >= 3'd5 || (q * 64'd5 + 64'(r)) !== x) begin
                bad++;
                $display("[TB] FAIL random%0d x=%h got=%h/%0d want=%h/%0d ok=%b",
                         i, x, q, r, eq, er, ok);
            end
        end
    endtask

    // Sequence of scenarios, then the summary.
    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_zero();
        test_values();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
